// File: rtl/backup_pkg.sv
// Shared types and constants for the NeoGeo backup RAM controller.
//   state_t : autosave FSM states
//   LANE_W  : width of one RAM bank word (one 68K word)
//   BE_W    : byte enables per bank word
//   sel_w() : bank-select width for a given lane count (0 when LANES=1)
package backup_pkg;

  typedef enum logic [1:0] {IDLE, DIRTY, REQ, SAVING} state_t;

  localparam int LANE_W = 16;
  localparam int BE_W   = 2;

  function automatic int sel_w(input int lanes);
    return (lanes <= 1) ? 0 : $clog2(lanes);
  endfunction

endpackage

// File: rtl/backup_bank.sv
// One 16-bit bank of the backup RAM: single-clock true dual port.
//   clk, rst_n        : clock, async active-low reset (read registers only)
//   a_addr/a_we/a_be  : 68K port, byte-enabled write
//   a_din/a_dout      : 68K port data, dout registered, read-first
//   b_addr/b_we       : host port, full-word write
//   b_din/b_dout      : host port data, dout registered, read-first
// When both ports write the same word in one cycle the host port wins.
module backup_bank
  import backup_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     a_addr,
  input  logic              a_we,
  input  logic [BE_W-1:0]   a_be,
  input  logic [LANE_W-1:0] a_din,
  output logic [LANE_W-1:0] a_dout,
  input  logic [AW-1:0]     b_addr,
  input  logic              b_we,
  input  logic [LANE_W-1:0] b_din,
  output logic [LANE_W-1:0] b_dout
);

  logic [LANE_W-1:0] mem [2**AW];

  // Contents survive reset (battery backed). Port B is written last so a
  // same-word collision keeps the host data.
  always_ff @(posedge clk) begin
    if (a_we)
      for (int i = 0; i < BE_W; i++)
        if (a_be[i]) mem[a_addr][i*8 +: 8] <= a_din[i*8 +: 8];
    if (b_we) mem[b_addr] <= b_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dout <= '0;
      b_dout <= '0;
    end else begin
      a_dout <= mem[a_addr];
      b_dout <= mem[b_addr];
    end
  end

endmodule

// File: rtl/backup_ram_ctrl.sv
// NeoGeo battery-backed SRAM controller with dirty tracking and autosave.
//   clk_sys, nRESET     : clock, async active-low reset
//   cpu_*               : 68K 16-bit port, active-low byte strobes, 1-cycle read
//   cpu_wp              : 1 = 68K writes dropped (RAM, dirty and FSM untouched)
//   host_*              : LANES x 16-bit save/load port, lane k = bank k
//   save_req / save_ack : autosave handshake, raised after QUIET_CYCLES idle
//   host_active         : host transfer in progress (ends a save)
//   dirty               : RAM differs from the last saved image
module backup_ram_ctrl
  import backup_pkg::*;
#(
  parameter int ADDR_W       = 15,
  parameter int LANES        = 2,
  parameter int QUIET_CYCLES = 24000000,
  parameter int CNT_W        = 25
) (
  input  logic                              clk_sys,
  input  logic                              nRESET,
  input  logic [ADDR_W-1:0]                 cpu_addr,
  input  logic                              cpu_nbwl,
  input  logic                              cpu_nbwu,
  input  logic [LANE_W-1:0]                 cpu_din,
  output logic [LANE_W-1:0]                 cpu_dout,
  input  logic                              cpu_wp,
  input  logic [ADDR_W-sel_w(LANES)-1:0]    host_addr,
  input  logic                              host_wr,
  input  logic [LANE_W*LANES-1:0]           host_din,
  output logic [LANE_W*LANES-1:0]           host_dout,
  input  logic                              host_active,
  output logic                              save_req,
  input  logic                              save_ack,
  output logic                              dirty
);

  localparam int SEL_W = sel_w(LANES);
  localparam int SW1   = (SEL_W == 0) ? 1 : SEL_W;
  localparam int BA_W  = ADDR_W - SEL_W;
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);

  logic [BA_W-1:0]  cpu_baddr;
  logic [SW1-1:0]   cpu_bank, cpu_bank_q;
  logic             cpu_we;
  logic [BE_W-1:0]  cpu_be;
  logic [LANES-1:0][LANE_W-1:0] a_dout, b_dout;

  assign cpu_be = {~cpu_nbwu, ~cpu_nbwl};
  assign cpu_we = (|cpu_be) & ~cpu_wp;

  if (SEL_W == 0) begin : g_one_bank
    assign cpu_bank  = '0;
    assign cpu_baddr = cpu_addr;
  end else begin : g_banked
    assign cpu_bank  = cpu_addr[SEL_W-1:0];
    assign cpu_baddr = cpu_addr[ADDR_W-1:SEL_W];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_bank
    backup_bank #(.AW(BA_W)) u_bank (
      .clk    (clk_sys),
      .rst_n  (nRESET),
      .a_addr (cpu_baddr),
      .a_we   (cpu_we && (cpu_bank == SW1'(k))),
      .a_be   (cpu_be),
      .a_din  (cpu_din),
      .a_dout (a_dout[k]),
      .b_addr (host_addr),
      .b_we   (host_wr),
      .b_din  (host_din[k*LANE_W +: LANE_W]),
      .b_dout (b_dout[k])
    );
  end

  // Bank select travels with the read so the mux matches the registered data.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) cpu_bank_q <= '0;
    else         cpu_bank_q <= cpu_bank;
  end

  assign cpu_dout  = a_dout[cpu_bank_q];
  assign host_dout = b_dout;

  // Autosave FSM. A collided (lost) 68K write still counts as activity.
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rewrite, rewrite_nxt;

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      rewrite <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rewrite <= rewrite_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rewrite_nxt = rewrite;
    case (state)
      IDLE:
        if (cpu_we) begin
          state_nxt = DIRTY;
          cnt_nxt   = '0;
        end
      DIRTY:
        if (cpu_we)                 cnt_nxt   = '0;
        else if (cnt >= QUIET_LAST) state_nxt = REQ;   // counter parks here
        else                        cnt_nxt   = cnt + 1'b1;
      REQ:
        if (cpu_we) begin
          state_nxt = DIRTY;
          cnt_nxt   = '0;
        end else if (save_ack) begin
          state_nxt = SAVING;
        end
      SAVING: begin
        // A write in the final cycle of the save also makes the image stale.
        rewrite_nxt = rewrite | cpu_we;
        if (!host_active) begin
          rewrite_nxt = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = (rewrite | cpu_we) ? DIRTY : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign save_req = (state == REQ);
  assign dirty    = (state != IDLE);

endmodule

// File: tb/tb_backup_ram_ctrl.sv
// Randomized self-checking bench for backup_ram_ctrl (LANES=2, QUIET_CYCLES=8).
module tb_backup_ram_ctrl;

  localparam int AW = 6, L = 2, Q = 8, CW = 4, HAW = AW - 1, DEPTH = 64;

  logic          clk = 1'b0;
  logic          nRESET;
  logic [AW-1:0] cpu_addr;
  logic          cpu_nbwl, cpu_nbwu, cpu_wp;
  logic [15:0]   cpu_din, cpu_dout;
  logic [HAW-1:0] host_addr;
  logic          host_wr, host_active, save_req, save_ack, dirty;
  logic [31:0]   host_din, host_dout;

  backup_ram_ctrl #(.ADDR_W(AW), .LANES(L), .QUIET_CYCLES(Q), .CNT_W(CW)) dut (
    .clk_sys(clk), .nRESET(nRESET),
    .cpu_addr(cpu_addr), .cpu_nbwl(cpu_nbwl), .cpu_nbwu(cpu_nbwu),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wp(cpu_wp),
    .host_addr(host_addr), .host_wr(host_wr), .host_din(host_din),
    .host_dout(host_dout), .host_active(host_active),
    .save_req(save_req), .save_ack(save_ack), .dirty(dirty)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: flat word array plus save-protocol flags.
  logic [15:0] mem_m [DEPTH];
  bit          m_dirty, m_req, m_saving, m_rew;
  int          m_quiet;
  logic [15:0] e_cpu;
  logic [31:0] e_host;

  task automatic model_reset();
    m_dirty = 0; m_req = 0; m_saving = 0; m_rew = 0; m_quiet = 0;
    e_cpu = '0; e_host = '0;
  endtask

  task automatic model_edge();
    bit w;
    w = (!cpu_nbwl || !cpu_nbwu) && !cpu_wp;
    e_cpu  = mem_m[cpu_addr];
    e_host = {mem_m[{host_addr, 1'b1}], mem_m[{host_addr, 1'b0}]};
    if (w) begin
      if (!cpu_nbwl) mem_m[cpu_addr][7:0]  = cpu_din[7:0];
      if (!cpu_nbwu) mem_m[cpu_addr][15:8] = cpu_din[15:8];
    end
    if (host_wr) begin
      mem_m[{host_addr, 1'b0}] = host_din[15:0];
      mem_m[{host_addr, 1'b1}] = host_din[31:16];
    end
    if (m_saving) begin
      if (w) m_rew = 1;
      if (!host_active) begin
        m_saving = 0;
        m_dirty  = m_rew;
        m_quiet  = 0;
        m_rew    = 0;
      end
    end else if (m_req) begin
      if (w) begin m_req = 0; m_quiet = 0; end
      else if (save_ack) begin m_req = 0; m_saving = 1; end
    end else if (m_dirty) begin
      if (w) m_quiet = 0;
      else if (m_quiet == Q - 1) m_req = 1;
      else m_quiet++;
    end else if (w) begin
      m_dirty = 1; m_quiet = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!nRESET) model_reset(); else model_edge();
    #1;
    if (cmp_en) begin
      chk("cpu_dout",  {16'h0, cpu_dout}, {16'h0, e_cpu});
      chk("host_dout", host_dout, e_host);
      chk("save_req",  {31'h0, save_req}, {31'h0, m_req});
      chk("dirty",     {31'h0, dirty},    {31'h0, m_dirty});
    end
  endtask

  task automatic idle();
    cpu_nbwl = 1; cpu_nbwu = 1; cpu_wp = 0; host_wr = 0; save_ack = 0;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
    cpu_addr = a; cpu_din = d; cpu_nbwl = ~be[0]; cpu_nbwu = ~be[1];
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    idle();
    while (!save_req && n < 40) begin tick(); n++; end
    chk("req_timeout", {31'h0, save_req}, 32'h1);
  endtask

  task automatic do_save(input bit wr_during);
    save_ack = 1; host_active = 1;
    tick();
    save_ack = 0;
    for (int i = 0; i < 4; i++) begin
      if (wr_during && i == 2) cpu_write(AW'($urandom), 16'($urandom), 2'b11);
      else idle();
      tick();
    end
    idle(); host_active = 0;
    tick();
  endtask

  task automatic quiet_run(input string tag);
    idle();
    for (int i = 1; i <= Q; i++) begin
      tick();
      chk(tag, {31'h0, save_req}, {31'h0, (i == Q)});
    end
  endtask

  logic [31:0] hv;

  initial begin
    nRESET = 1; idle(); host_active = 0;
    cpu_addr = '0; cpu_din = '0; host_addr = '0; host_din = '0;
    model_reset();
    #2 nRESET = 0;
    #3;
    chk("rst_cpu_dout",  {16'h0, cpu_dout}, 32'h0);
    chk("rst_host_dout", host_dout, 32'h0);
    chk("rst_save_req",  {31'h0, save_req}, 32'h0);
    chk("rst_dirty",     {31'h0, dirty}, 32'h0);
    tick(); tick();
    nRESET = 1;

    // Load an image from the host side; must not mark the RAM dirty.
    for (int a = 0; a < DEPTH / L; a++) begin
      host_addr = HAW'(a); host_din = $urandom; host_wr = 1;
      tick();
    end
    idle(); tick();
    cmp_en = 1;
    chk("load_dirty", {31'h0, dirty}, 32'h0);

    // Word write, readback on both ports.
    cpu_write(6'd5, 16'hBEEF, 2'b11); host_addr = 5'd2;
    tick();
    idle(); tick();
    chk("beef_cpu",     {16'h0, cpu_dout}, 32'h0000BEEF);
    chk("beef_host_hi", {16'h0, host_dout[31:16]}, 32'h0000BEEF);
    chk("beef_dirty",   {31'h0, dirty}, 32'h1);

    // Upper-byte-only write.
    cpu_write(6'd9, 16'hFFFF, 2'b11); tick();
    cpu_write(6'd9, 16'h1234, 2'b10); tick();
    idle(); tick();
    chk("byte_lane", {16'h0, cpu_dout}, 32'h000012FF);

    wait_req();
    do_save(0);
    chk("save_clean_dirty", {31'h0, dirty}, 32'h0);

    // Quiet timing from a single write, then a restart at idle cycle 5.
    cpu_write(AW'($urandom), 16'($urandom), 2'b11); tick();
    chk("t0_dirty", {31'h0, dirty}, 32'h1);
    quiet_run("quiet_req");
    cpu_write(AW'($urandom), 16'($urandom), 2'b01); tick();
    idle(); repeat (5) tick();
    chk("restart_no_req", {31'h0, save_req}, 32'h0);
    cpu_write(AW'($urandom), 16'($urandom), 2'b11); tick();
    quiet_run("restart_req");

    // Write during SAVING: image is stale again.
    do_save(1);
    chk("rewrite_dirty", {31'h0, dirty}, 32'h1);
    quiet_run("rewrite_req");
    do_save(0);
    chk("save2_dirty", {31'h0, dirty}, 32'h0);

    // Write-protected writes are dropped.
    for (int i = 0; i < 10; i++) begin
      cpu_write(AW'($urandom), 16'($urandom), 2'($urandom_range(1, 3)));
      cpu_wp = 1; tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin cpu_addr = AW'(i); tick(); end
    chk("wp_dirty", {31'h0, dirty}, 32'h0);

    // Same-word collision: host data wins, dirty still set.
    hv = $urandom;
    host_addr = 5'd7; host_din = hv; host_wr = 1;
    cpu_write(6'd15, ~hv[31:16], 2'b11);
    tick();
    idle(); cpu_addr = 6'd15; tick();
    chk("collide_data",  {16'h0, cpu_dout}, {16'h0, hv[31:16]});
    chk("collide_dirty", {31'h0, dirty}, 32'h1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      idle();
      cpu_addr = AW'($urandom); cpu_din = 16'($urandom);
      host_addr = HAW'($urandom); host_din = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        hv[1:0] = 2'($urandom_range(1, 3));
        cpu_nbwl = ~hv[0]; cpu_nbwu = ~hv[1];
        cpu_wp = ($urandom_range(0, 4) == 0);
      end
      host_wr  = ($urandom_range(0, 9) == 0);
      save_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) host_active = ~host_active;
      tick();
    end
    idle(); host_active = 0; tick();

    // Reset in the middle of a save.
    cpu_write(AW'($urandom), 16'($urandom), 2'b11); tick();
    wait_req();
    save_ack = 1; host_active = 1; tick();
    save_ack = 0; tick();
    #2 nRESET = 0;
    #1;
    model_reset();
    chk("midsave_cpu_dout",  {16'h0, cpu_dout}, 32'h0);
    chk("midsave_host_dout", host_dout, 32'h0);
    chk("midsave_save_req",  {31'h0, save_req}, 32'h0);
    chk("midsave_dirty",     {31'h0, dirty}, 32'h0);
    host_active = 0;
    tick();
    nRESET = 1;
    for (int i = 0; i < 16; i++) begin
      cpu_addr = AW'($urandom); host_addr = HAW'($urandom);
      tick();
    end
    chk("post_rst_dirty", {31'h0, dirty}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/backup_ram_ctrl.md
Name: backup_ram_ctrl

Overview:
- Parametrised battery-backed SRAM controller for the NeoGeo backup RAM.
- 68K-side 16-bit port with byte lanes.
- Host-side save/load port of configurable width, built from LANES interleaved 16-bit banks.
- Adds dirty tracking, a write-protect gate and an autosave request handshake: the core raises save_req after the 68K has stopped writing for QUIET_CYCLES.

Parameters:
- ADDR_W, 15: 68K word-address width; depth = 2^ADDR_W 16-bit words.
- LANES, 2: host word = LANES×16 bits. Legal values are 1, 2 and 4.
- QUIET_CYCLES, 24000000: idle cycles after the last 68K write before save_req rises. Must be ≥1.
- CNT_W, 25: quiet counter width; must satisfy 2^CNT_W > QUIET_CYCLES.

Ports:
- clk_sys  in  1  sole clock; both ports are synchronous to it.
- nRESET  in  1  asynchronous, active-low reset.
- cpu_addr  in  ADDR_W  68K word address.
- cpu_nbwl  in  1  active-low low-byte write strobe.
- cpu_nbwu  in  1  active-low high-byte write strobe.
- cpu_din  in  16  68K write data.
- cpu_dout  out  16  68K read data.
- cpu_wp  in  1  write protect; 1 = 68K writes ignored.
- host_addr  in  ADDR_W-log2(LANES)  host word address.
- host_wr  in  1  host write strobe (load from SD).
- host_din  in  16×LANES  host write data; lane 0 in bits [15:0].
- host_dout  out  16×LANES  host read data (save to SD).
- host_active  in  1  host save/load transfer in progress.
- save_req  out  1  autosave request.
- save_ack  in  1  host accepts the request.
- dirty  out  1  RAM differs from the last saved image.

Behaviour:
- Banking:
  - bank = cpu_addr[log2(LANES)-1:0]; in-bank address = cpu_addr[ADDR_W-1:log2(LANES)].
  - Host lane k maps to bank k at host_addr.
- 68K write:
  - Occurs when (~cpu_nbwl | ~cpu_nbwu) & ~cpu_wp.
  - Byte enables = {~cpu_nbwu, ~cpu_nbwl}; only the selected bank is written.
- Read latency:
  - cpu_dout and host_dout are registered, 1 cycle after the address.
  - Read-during-write on the same port returns old data.
  - cpu_dout uses the bank select registered alongside the address.
- Collision: host_wr and a 68K write to the same bank word in the same cycle → host data stored; the 68K write is lost but still counts as a write for dirty and FSM purposes.
- Host writes never set dirty and never touch the FSM. A load leaves dirty unchanged.
- Reset values: cpu_dout=0, host_dout=0, save_req=0, dirty=0, state=IDLE, quiet counter=0. RAM contents are not cleared.
- FSM, where W = accepted 68K write this cycle:
  - IDLE: W → DIRTY, dirty=1, counter cleared.
  - DIRTY:
    - W → counter cleared.
    - Otherwise counter increments.
    - Counter reaches QUIET_CYCLES-1 with no W → REQ, save_req=1 on the next cycle.
  - REQ:
    - save_req held high until save_ack.
    - W in REQ → back to DIRTY, save_req=0, counter cleared; W takes priority over a same-cycle save_ack.
    - save_ack without W → SAVING, save_req=0.
  - SAVING:
    - Waits for host_active to fall.
    - Any W during SAVING sets internal flag rewrite.
    - On host_active falling: if rewrite, go to DIRTY (counter cleared, dirty stays 1); else go to IDLE with dirty=0. rewrite is cleared on exit.
  - save_ack in IDLE or DIRTY is ignored.
- cpu_wp=1: writes are invisible to the FSM and to dirty.
- Reset mid-save: returns to IDLE with dirty=0. Losing the pending-save indication is accepted.
- Counter saturates; it never wraps.

Decomposition:
- Package backup_pkg holds:
  - state enum {IDLE, DIRTY, REQ, SAVING};
  - constants LANE_W=16 and BE_W=2;
  - function for the bank-select width, log2(LANES), returning 0 when LANES=1.
- Sub-module backup_bank: 16-bit true-dual-port RAM, single clock, byte-enable port A, read-first. Instantiated LANES times via generate.

Test Plan:
- LANES=2. 68K writes 0xBEEF at cpu_addr 5 (both strobes) → host_dout at host_addr 2 = 0xBEEF_xxxx one cycle after the address; cpu_dout at addr 5 = 0xBEEF.
- Byte lanes: write 0x1234 with only cpu_nbwu=0 over 0xFFFF → readback 0x12FF.
- QUIET_CYCLES=8. Single write at t0:
  - dirty=1 at t0+1;
  - save_req rises exactly 8 idle cycles later;
  - a write at cycle 5 restarts the count.
- REQ with save_ack, host_active pulsed 4 cycles → dirty=0 after host_active falls. Repeat with one 68K write during SAVING → DIRTY, dirty stays 1, save_req reasserts after 8 quiet cycles.
- cpu_wp=1 writes → RAM unchanged, dirty stays 0. Same-cycle host_wr and 68K write to one word → host value read back, dirty=1.
- nRESET low during SAVING → all outputs 0 asynchronously, state IDLE. RAM contents written before reset still read back afterwards.
